// File: rtl/alu_result_register_if.sv
// Control/data bundle between the SAP-U adder/control word and the sigma register.
// Define ALU_OVERFLOW_EN to add the signed-overflow inputs and flag.
interface alu_result_register_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] sum_in;
  logic             cout_in;
  logic             operand_chg;
  logic             result_load;
  logic             flags_load;
  logic             bus_oe;
  logic [WIDTH-1:0] result;
  logic             carry_flag;
  logic             zero_flag;
  logic             ready;
  logic             load_pending;
  logic [WIDTH-1:0] bus_out;
  logic             bus_drive;
`ifdef ALU_OVERFLOW_EN
  logic             a_msb;
  logic             b_eff_msb;
  logic             overflow_flag;
`endif

  modport master (
    output sum_in, cout_in, operand_chg, result_load, flags_load, bus_oe,
`ifdef ALU_OVERFLOW_EN
    output a_msb, b_eff_msb,
    input  overflow_flag,
`endif
    input  result, carry_flag, zero_flag, ready, load_pending, bus_out, bus_drive
  );

  modport slave (
    input  sum_in, cout_in, operand_chg, result_load, flags_load, bus_oe,
`ifdef ALU_OVERFLOW_EN
    input  a_msb, b_eff_msb,
    output overflow_flag,
`endif
    output result, carry_flag, zero_flag, ready, load_pending, bus_out, bus_drive
  );
endinterface

// File: rtl/alu_result_register.sv
// Sigma register and carry/zero flags behind the ripple adder, with settle-time load deferral.
// Define ALU_OVERFLOW_EN to also capture a signed overflow flag under the flag strobe.
//
// state    | meaning
// READY    | adder output settled; loads capture immediately
// SETTLING | operands changed recently; loads are deferred as pending
module alu_result_register #(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 2
) (
  input logic                clk,
  input logic                rst,
  alu_result_register_if.slave alu
);
  localparam int CW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES);
  localparam logic [CW-1:0] COUNT_LAST  = CW'(1);

  typedef enum logic {READY, SETTLING} state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic             res_pending;
  logic             flg_pending;
  logic [WIDTH-1:0] result_q;
  logic             carry_q;
  logic             zero_q;
  logic             chg;
  logic             capture;
  logic             res_req;
  logic             flg_req;

  // With no settle time the sum is always valid, so operand changes never block a capture.
  assign chg     = (SETTLE_CYCLES > 0) && alu.operand_chg;
  assign capture = (state == READY) && !chg;
  assign res_req = alu.result_load | res_pending;
  assign flg_req = alu.flags_load | flg_pending;

`ifdef ALU_OVERFLOW_EN
  logic ovf_q;
  logic ovf_next;
  assign ovf_next = (alu.a_msb == alu.b_eff_msb) && (alu.sum_in[WIDTH-1] != alu.a_msb);
  assign alu.overflow_flag = ovf_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= READY;
      count       <= '0;
      res_pending <= 1'b0;
      flg_pending <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
`ifdef ALU_OVERFLOW_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      if (chg) begin
        state <= SETTLING;
        count <= SETTLE_LOAD;
      end else if (state == SETTLING) begin
        if (count == COUNT_LAST) begin
          state <= READY;
          count <= '0;
        end else begin
          count <= count - 1'b1;
        end
      end

      if (res_req) begin
        if (capture) begin
          result_q    <= alu.sum_in;
          res_pending <= 1'b0;
        end else begin
          res_pending <= 1'b1;
        end
      end

      if (flg_req) begin
        if (capture) begin
          carry_q     <= alu.cout_in;
          zero_q      <= (alu.sum_in == '0);
`ifdef ALU_OVERFLOW_EN
          ovf_q       <= ovf_next;
`endif
          flg_pending <= 1'b0;
        end else begin
          flg_pending <= 1'b1;
        end
      end
    end
  end

  assign alu.result       = result_q;
  assign alu.carry_flag   = carry_q;
  assign alu.zero_flag    = zero_q;
  assign alu.ready        = (state == READY);
  assign alu.load_pending = res_pending | flg_pending;
  assign alu.bus_out      = alu.bus_oe ? result_q : '0;
  assign alu.bus_drive    = alu.bus_oe;
endmodule
